// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding imem request, buffers into a 2-entry FIFO.
// Optional JAL predecode redirect is enabled by defining IFU_JAL_PREDICT_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_branch_taken,
    input  logic [31:0] i_pc_branch,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_insn,
    output logic        o_if_pred_taken,
    input  logic        i_id_ready
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        kill_q;
    logic [31:0] fifo_pc   [2];
    logic [31:0] fifo_insn [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic grant;
    logic push;
    logic pop;
    logic unused_branch_lsbs;

    // With a single outstanding request, nothing is in flight while in REQ.
    assign o_imem_req  = (state == REQ) && (count < 2'd2);
    assign o_imem_addr = {pc_q[31:2], 2'b00};
    assign o_if_valid  = (count != 2'd0);
    assign o_if_pc     = o_if_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign o_if_insn   = o_if_valid ? fifo_insn[rd_ptr] : 32'h0;

    assign grant = o_imem_req && i_imem_gnt;
    assign push  = (state == WAIT) && i_imem_rvalid && !kill_q;
    assign pop   = o_if_valid && i_id_ready;

    assign unused_branch_lsbs = ^i_pc_branch[1:0];

`ifdef IFU_JAL_PREDICT_EN
    logic [1:0]  fifo_pred;
    logic        is_jal;
    logic [31:0] jal_target;

    assign is_jal     = (i_imem_rdata[6:0] == 7'b1101111);
    assign jal_target = req_pc_q + {{11{i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[19:12],
                                    i_imem_rdata[20], i_imem_rdata[30:21], 1'b0};
    assign o_if_pred_taken = o_if_valid && fifo_pred[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fifo_pred <= 2'b00;
        end else if (push && !i_branch_taken) begin
            fifo_pred[wr_ptr] <= is_jal;
        end
    end
`else
    assign o_if_pred_taken = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
            kill_q   <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]   <= 32'h0;
                fifo_insn[i] <= 32'h0;
            end
        end else if (i_branch_taken) begin
            // A redirect flushes everything; a response still owed by memory must be discarded later.
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            pc_q   <= {i_pc_branch[31:2], 2'b00};
            if (((state == WAIT) && !i_imem_rvalid) || grant) begin
                kill_q <= 1'b1;
                state  <= WAIT;
            end else begin
                kill_q <= 1'b0;
                state  <= REQ;
            end
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (grant) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        kill_q <= 1'b0;
                        state  <= REQ;
`ifdef IFU_JAL_PREDICT_EN
                        if (!kill_q && is_jal) begin
                            pc_q <= jal_target;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
            if (push) begin
                fifo_pc[wr_ptr]   <= req_pc_q;
                fifo_insn[wr_ptr] <= i_imem_rdata;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch with an always-granting, one-cycle-latency memory model.
module tb_ifu_fetch;

    logic        i_clk;
    logic        i_rst;
    logic        i_branch_taken;
    logic [31:0] i_pc_branch;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_if_valid;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_insn;
    logic        o_if_pred_taken;
    logic        i_id_ready;

    int          compareCount;
    int          mismatchCount;
    logic        respPending;
    logic [31:0] respAddr;
    logic        granted;
    logic [31:0] grantAddr;

    ifu_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_branch_taken (i_branch_taken),
        .i_pc_branch    (i_pc_branch),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_gnt     (i_imem_gnt),
        .i_imem_rvalid  (i_imem_rvalid),
        .i_imem_rdata   (i_imem_rdata),
        .o_if_valid     (o_if_valid),
        .o_if_pc        (o_if_pc),
        .o_if_insn      (o_if_insn),
        .o_if_pred_taken(o_if_pred_taken),
        .i_id_ready     (i_id_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Instruction memory image: a JAL x0,+8 at 0x200, otherwise an address-tagged non-JAL word.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0000_0200) return 32'h0080_006F;
        return {addr[24:0], 7'h13};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, let memory answer the previous grant, track the new grant.
    task automatic applyStimulus(input logic branch, input logic [31:0] target, input logic ready,
                                 input logic respEnable);
        i_branch_taken = branch;
        i_pc_branch    = target;
        i_id_ready     = ready;
        i_imem_rvalid  = respPending && respEnable && !i_rst;
        i_imem_rdata   = i_imem_rvalid ? memWord(respAddr) : 32'h0;
        #2;
        granted   = !i_rst && o_imem_req && i_imem_gnt;
        grantAddr = o_imem_addr;
        @(posedge i_clk);
        #1;
        if (i_rst) begin
            respPending = 1'b0;
        end else begin
            if (i_imem_rvalid) respPending = 1'b0;
            if (granted) begin
                respPending = 1'b1;
                respAddr    = grantAddr;
            end
        end
    endtask

    task automatic resetDut();
        i_rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic idle(input logic ready);
        applyStimulus(1'b0, 32'h0, ready, 1'b1);
    endtask

    initial begin
        compareCount   = 0;
        mismatchCount  = 0;
        respPending    = 1'b0;
        respAddr       = 32'h0;
        i_rst          = 1'b1;
        i_branch_taken = 1'b0;
        i_pc_branch    = 32'h0;
        i_imem_gnt     = 1'b1;
        i_imem_rvalid  = 1'b0;
        i_imem_rdata   = 32'h0;
        i_id_ready     = 1'b0;

        resetDut();
        checkOutput("rst_req",   {31'h0, o_imem_req},      32'h0);
        checkOutput("rst_valid", {31'h0, o_if_valid},      32'h0);
        checkOutput("rst_pred",  {31'h0, o_if_pred_taken}, 32'h0);
        checkOutput("rst_pc",    o_if_pc,                  32'h0);
        checkOutput("rst_insn",  o_if_insn,                32'h0);
        checkOutput("rst_addr",  o_imem_addr,              32'h0000_0100);
        i_rst = 1'b0;

        // Streaming with ID always ready: one instruction every two cycles.
        idle(1'b1);
        checkOutput("s_req0",  {31'h0, o_imem_req}, 32'h1);
        checkOutput("s_addr0", o_imem_addr,         32'h0000_0100);
        idle(1'b1);
        checkOutput("s_wait0", {31'h0, o_imem_req}, 32'h0);
        checkOutput("s_addr1", o_imem_addr,         32'h0000_0104);
        idle(1'b1);
        checkOutput("s_val0",  {31'h0, o_if_valid}, 32'h1);
        checkOutput("s_pc0",   o_if_pc,             32'h0000_0100);
        checkOutput("s_insn0", o_if_insn,           {25'h100, 7'h13});
        idle(1'b1);
        checkOutput("s_gap0",  {31'h0, o_if_valid}, 32'h0);
        checkOutput("s_addr2", o_imem_addr,         32'h0000_0108);
        idle(1'b1);
        checkOutput("s_pc1",   o_if_pc,             32'h0000_0104);
        idle(1'b1);
        checkOutput("s_gap1",  {31'h0, o_if_valid}, 32'h0);
        idle(1'b1);
        checkOutput("s_pc2",   o_if_pc,             32'h0000_0108);

        // Backpressure: exactly two entries buffered, requests held off.
        resetDut();
        i_rst = 1'b0;
        for (int i = 0; i < 10; i++) idle(1'b0);
        checkOutput("bp_req",   {31'h0, o_imem_req}, 32'h0);
        checkOutput("bp_valid", {31'h0, o_if_valid}, 32'h1);
        checkOutput("bp_pc",    o_if_pc,             32'h0000_0100);
        checkOutput("bp_addr",  o_imem_addr,         32'h0000_0108);
        idle(1'b1);
        checkOutput("bp_pop1",  o_if_pc,             32'h0000_0104);
        checkOutput("bp_req1",  {31'h0, o_imem_req}, 32'h1);
        idle(1'b1);
        checkOutput("bp_empty", {31'h0, o_if_valid}, 32'h0);
        checkOutput("bp_addr2", o_imem_addr,         32'h0000_010C);
        idle(1'b1);
        checkOutput("bp_pc2",   o_if_pc,             32'h0000_0108);

        // Redirect to 0x3002 in the same cycle 0x10C is granted.
        applyStimulus(1'b1, 32'h0000_3002, 1'b1, 1'b1);
        checkOutput("rg_valid", {31'h0, o_if_valid}, 32'h0);
        checkOutput("rg_req",   {31'h0, o_imem_req}, 32'h0);
        checkOutput("rg_addr",  o_imem_addr,         32'h0000_3000);
        idle(1'b1);
        checkOutput("rg_drop",  {31'h0, o_if_valid}, 32'h0);
        checkOutput("rg_req2",  {31'h0, o_imem_req}, 32'h1);
        checkOutput("rg_addr2", o_imem_addr,         32'h0000_3000);
        idle(1'b1);
        idle(1'b1);
        checkOutput("rg_valid2", {31'h0, o_if_valid}, 32'h1);
        checkOutput("rg_pc",     o_if_pc,             32'h0000_3000);
        checkOutput("rg_insn",   o_if_insn,           {25'h3000, 7'h13});

        // Redirect to 0x2000 in WAIT; the stale response arrives one cycle later.
        idle(1'b1);
        applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b0);
        checkOutput("rw_addr",  o_imem_addr,         32'h0000_2000);
        checkOutput("rw_req",   {31'h0, o_imem_req}, 32'h0);
        idle(1'b1);
        checkOutput("rw_drop",  {31'h0, o_if_valid}, 32'h0);
        checkOutput("rw_req2",  {31'h0, o_imem_req}, 32'h1);
        idle(1'b1);
        idle(1'b1);
        checkOutput("rw_pc",    o_if_pc,             32'h0000_2000);
        checkOutput("rw_insn",  o_if_insn,           {25'h2000, 7'h13});

        // Redirect coinciding with rvalid: data dropped, no kill, PC wraps after 0xFFFF_FFFC.
        idle(1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        checkOutput("wr_valid", {31'h0, o_if_valid}, 32'h0);
        checkOutput("wr_req",   {31'h0, o_imem_req}, 32'h1);
        checkOutput("wr_addr",  o_imem_addr,         32'hFFFF_FFFC);
        idle(1'b1);
        checkOutput("wr_wrap",  o_imem_addr,         32'h0000_0000);
        idle(1'b1);
        checkOutput("wr_pc",    o_if_pc,             32'hFFFF_FFFC);

        // JAL x0,+8 at 0x200.
        idle(1'b1);
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        checkOutput("j_addr",  o_imem_addr, 32'h0000_0200);
        idle(1'b1);
        idle(1'b1);
        checkOutput("j_pc",    o_if_pc,     32'h0000_0200);
        checkOutput("j_insn",  o_if_insn,   32'h0080_006F);
`ifdef IFU_JAL_PREDICT_EN
        checkOutput("j_pred",  {31'h0, o_if_pred_taken}, 32'h1);
        checkOutput("j_next",  o_imem_addr,              32'h0000_0208);
`else
        checkOutput("j_pred",  {31'h0, o_if_pred_taken}, 32'h0);
        checkOutput("j_next",  o_imem_addr,              32'h0000_0204);
`endif

        // Back-to-back redirects: the second one wins.
        idle(1'b1);
        applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0500, 1'b1, 1'b1);
        checkOutput("bb_addr", o_imem_addr,         32'h0000_0500);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        checkOutput("bb_valid", {31'h0, o_if_valid}, 32'h1);
        checkOutput("bb_pc",    o_if_pc,             32'h0000_0500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
